// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: word width, opcode map and fetch FSM encoding.
package fetch_unit_pkg;

  localparam int WORD_W = 8;

  localparam logic [3:0] OPC_LOAD  = 4'b0000;
  localparam logic [3:0] OPC_STORE = 4'b0001;
  localparam logic [3:0] OPC_LDI   = 4'b0010;
  localparam logic [3:0] OPC_MOV   = 4'b0011;
  localparam logic [3:0] OPC_HLT   = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  // True when the upper nibble of an instruction byte matches the given opcode.
  function automatic logic is_opcode(input logic [WORD_W-1:0] instr, input logic [3:0] opc);
    return (instr[WORD_W-1:WORD_W-4] == opc);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory wait counter: counts FETCH cycles without ack, flags the last allowed cycle.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count;

  // Clear has priority over counting so a new fetch always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (clr) begin
      count <= {CW{1'b0}};
    end else if (en) begin
      count <= count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // The current cycle is the final one in which an ack is still accepted.
  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, imem handshake, halt/timeout handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         TIMEOUT  = 16,
  parameter logic [3:0] HLT_OPC  = OPC_HLT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ack,
  output logic [7:0]  instruction,
  output logic        instr_valid,
  input  logic        pc_clk,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic [7:0]  pc,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] icount
);

  fetch_state_e state;
  logic         in_fetch;
  logic         tmo_expired;

  assign in_fetch  = (state == ST_FETCH);
  assign imem_req  = in_fetch;
  assign imem_addr = pc;

  // Counter runs only while waiting in FETCH; any ack or leaving FETCH resets it.
  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_fetch || imem_ack),
    .en      (in_fetch && !imem_ack && !tmo_expired),
    .expired (tmo_expired)
  );

  // Fetch FSM together with the PC, instruction register and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instruction <= 8'h00;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      icount      <= 16'h0000;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            if (is_opcode(imem_rdata, HLT_OPC)) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state       <= ST_HOLD;
              instr_valid <= 1'b1;
            end
          end else if (tmo_expired) begin
            state     <= ST_HALT;
            halted    <= 1'b1;
            fetch_err <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Branch inputs only matter when the control unit retires the instruction.
          if (pc_clk) begin
            pc          <= br_taken ? br_target : (pc + 8'd1);
            instr_valid <= 1'b0;
            if (icount != 16'hFFFF) begin
              icount <= icount + 16'd1;
            end
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          // Unreachable encoding: park safely and report as halted.
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a scoreboard of fetched instruction bytes.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_ack;
  logic [7:0]  instruction;
  logic        instr_valid;
  logic        pc_clk;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [7:0]  pc;
  logic        halted;
  logic        fetch_err;
  logic [15:0] icount;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_icount;
  logic [7:0]  sb[$];

  fetch_unit #(
    .RESET_PC (8'h00),
    .TIMEOUT  (16),
    .HLT_OPC  (4'hF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc_clk      (pc_clk),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc          (pc),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .icount      (icount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc     = 8'h00;
    exp_icount = 16'h0000;
    sb.delete();
  endtask

  // Drive one fetch with the given number of wait cycles; check request, address and capture.
  task automatic fetch_one(input logic [7:0] data, input int waits);
    int n;
    logic [7:0] e;
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req !== 1'b1) begin
        failures++;
        $display("FAIL fetch_req cyc=%0d got=%b exp=1", i, imem_req);
      end
      checks++;
      if (imem_addr !== exp_pc) begin
        failures++;
        $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", i, imem_addr, exp_pc);
      end
      if (i == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
        if (data[7:4] != 4'hF) sb.push_back(data);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom_range(255, 0));
      end
      tick();
    end
    imem_ack = 1'b0;
    if (data[7:4] != 4'hF) begin
      n = 0;
      while (instr_valid !== 1'b1 && n < 4) begin
        tick();
        n++;
      end
      checks++;
      if (n != 0) begin
        failures++;
        $display("FAIL valid_latency got=%0d exp=0 extra cycles", n);
      end
      checks++;
      if (instr_valid !== 1'b1) begin
        failures++;
        $display("FAIL instr_valid_wait got=%b exp=1", instr_valid);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty got=%h exp=none", instruction);
      end else begin
        e = sb.pop_front();
        if (instruction !== e) begin
          failures++;
          $display("FAIL instruction got=%h exp=%h", instruction, e);
        end
      end
    end
  endtask

  // Retire the held instruction, optionally branching; check the model PC and count.
  task automatic retire(input logic br, input logic [7:0] tgt);
    pc_clk    = 1'b1;
    br_taken  = br;
    br_target = tgt;
    tick();
    pc_clk    = 1'b0;
    br_taken  = 1'b0;
    br_target = 8'h00;
    exp_pc = br ? tgt : exp_pc + 8'd1;
    if (exp_icount != 16'hFFFF) exp_icount = exp_icount + 16'd1;
    checks++;
    if (pc !== exp_pc) begin
      failures++;
      $display("FAIL retire_pc got=%h exp=%h", pc, exp_pc);
    end
    checks++;
    if (icount !== exp_icount) begin
      failures++;
      $display("FAIL retire_icount got=%h exp=%h", icount, exp_icount);
    end
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL retire_state got valid=%b req=%b exp valid=0 req=1", instr_valid, imem_req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc, instruction, instr_valid, halted, fetch_err, icount, imem_req} !==
        {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got pc=%h ir=%h v=%b h=%b e=%b ic=%h req=%b exp 00 00 0 0 0 0000 1",
               pc, instruction, instr_valid, halted, fetch_err, icount, imem_req);
    end
  endtask

  task automatic test_zero_wait();
    fetch_one(8'h2D, 0);
    retire(1'b0, 8'h00);
  endtask

  task automatic test_wait_states();
    fetch_one(8'h13, 3);
    checks++;
    if (fetch_err !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL wait_no_err got err=%b halted=%b exp 0 0", fetch_err, halted);
    end
    retire(1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      d = {2'b00, 6'($urandom_range(63, 0))};
      fetch_one(d, int'($urandom_range(2, 0)));
      retire(1'b0, 8'h00);
    end
  endtask

  task automatic test_branch();
    checks++;
    if (pc !== 8'h05) begin
      failures++;
      $display("FAIL branch_start_pc got=%h exp=05", pc);
    end
    fetch_one(8'h21, 0);
    br_taken  = 1'b1;
    br_target = 8'h77;
    tick();
    tick();
    br_taken  = 1'b0;
    checks++;
    if (pc !== exp_pc || instr_valid !== 1'b1 || imem_req !== 1'b0 || icount !== exp_icount) begin
      failures++;
      $display("FAIL branch_no_pc_clk got pc=%h v=%b req=%b ic=%h exp pc=%h v=1 req=0 ic=%h",
               pc, instr_valid, imem_req, icount, exp_pc, exp_icount);
    end
    retire(1'b1, 8'h40);
    checks++;
    if (imem_addr !== 8'h40) begin
      failures++;
      $display("FAIL branch_addr got=%h exp=40", imem_addr);
    end
  endtask

  task automatic test_wrap();
    fetch_one(8'h30, 1);
    retire(1'b1, 8'hFF);
    fetch_one(8'h01, 0);
    retire(1'b0, 8'h00);
    checks++;
    if (imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL wrap_addr got=%h exp=00", imem_addr);
    end
  endtask

  task automatic test_saturate();
    imem_ack = 1'b0;
    force dut.icount = 16'hFFFE;
    tick();
    release dut.icount;
    exp_icount = 16'hFFFE;
    fetch_one(8'h02, 0);
    retire(1'b0, 8'h00);
    fetch_one(8'h03, 1);
    retire(1'b0, 8'h00);
  endtask

  task automatic test_halt();
    fetch_one(8'hF0, 1);
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== exp_pc) begin
      failures++;
      $display("FAIL halt_state got h=%b v=%b req=%b pc=%h exp h=1 v=0 req=0 pc=%h",
               halted, instr_valid, imem_req, pc, exp_pc);
    end
    pc_clk     = 1'b1;
    br_taken   = 1'b1;
    br_target  = 8'h99;
    imem_ack   = 1'b1;
    imem_rdata = 8'h2D;
    tick();
    pc_clk   = 1'b0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    tick();
    checks++;
    if (pc !== exp_pc || icount !== exp_icount || instruction !== 8'hF0 ||
        halted !== 1'b1 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL halt_ignores got pc=%h ic=%h ir=%h h=%b v=%b e=%b exp pc=%h ic=%h ir=F0 h=1 v=0 e=0",
               pc, icount, instruction, halted, instr_valid, fetch_err, exp_pc, exp_icount);
    end
    do_reset();
    checks++;
    if (pc !== 8'h00 || halted !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL halt_reset got pc=%h h=%b req=%b exp 00 0 1", pc, halted, imem_req);
    end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (halted !== 1'b0 || imem_req !== 1'b1) begin
        failures++;
        $display("FAIL timeout_early cyc=%0d got h=%b req=%b exp 0 1", i, halted, imem_req);
      end
      tick();
    end
    checks++;
    if (halted !== 1'b1 || fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_expire got h=%b e=%b req=%b exp 1 1 0", halted, fetch_err, imem_req);
    end
    imem_ack   = 1'b1;
    imem_rdata = 8'h2D;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instruction !== 8'h00 || fetch_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_late_ack got v=%b ir=%h e=%b exp 0 00 1", instr_valid, instruction, fetch_err);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    fetch_one(8'h2D, 0);
    retire(1'b0, 8'h00);
    fetch_one(8'h31, 1);
    rst    = 1'b1;
    pc_clk = 1'b1;
    tick();
    rst    = 1'b0;
    pc_clk = 1'b0;
    exp_pc     = 8'h00;
    exp_icount = 16'h0000;
    sb.delete();
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b1 || icount !== 16'h0000 ||
        fetch_err !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_hold got v=%b pc=%h req=%b ic=%h e=%b h=%b exp 0 00 1 0000 0 0",
               instr_valid, pc, imem_req, icount, fetch_err, halted);
    end
    fetch_one(8'h22, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_rdata = 8'h00;
    imem_ack   = 1'b0;
    pc_clk     = 1'b0;
    br_taken   = 1'b0;
    br_target  = 8'h00;
    exp_pc     = 8'h00;
    exp_icount = 16'h0000;
    tick();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_branch();
    test_wrap();
    test_saturate();
    test_halt();
    test_timeout();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
